glip_packet_depacketizer: RTL and testbench



---
 rtl/glip_packet_depacketizer.sv | 150 +++++++++++++++
 tb/tb_glip_packet_depacketizer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glip_packet_depacketizer.sv
// glip_packet_depacketizer: parses the FX2 receive word stream into framed
// packets. One header word per packet ([15:12] type, [11:0] length), payload
// forwarded through a single output register with type/last/err markers.
// Malformed headers are swallowed; packets starved mid-transfer are aborted
// and closed with a zero filler word flagged as an error.
module glip_packet_depacketizer #(
  parameter int MAX_LEN = 256,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_in_valid,
  input  logic [15:0] fifo_in_data,
  output logic        fifo_in_ready,
  output logic        pkt_valid,
  output logic [15:0] pkt_data,
  output logic [3:0]  pkt_type,
  output logic        pkt_last,
  output logic        pkt_err,
  input  logic        pkt_ready,
  output logic        drop,
  output logic [7:0]  err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_PAD  = 2'd3;

  localparam int            TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [11:0]   MAX_LEN_W = 12'(MAX_LEN);

  logic [1:0]    state;
  logic [11:0]   remaining;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    cur_type;

  logic        out_loadable;
  logic        in_fire;
  logic [11:0] hdr_len;
  logic        hdr_ok;
  logic        starved;
  logic        tmo_hit;
  logic        fwd_load;
  logic        pad_load;
  logic        reject;

  assign out_loadable = !pkt_valid || pkt_ready;
  assign in_fire      = fifo_in_valid && fifo_in_ready;
  assign hdr_len      = fifo_in_data[11:0];
  assign hdr_ok       = (hdr_len != 12'd0) && (hdr_len <= MAX_LEN_W);
  assign starved      = (TIMEOUT != 0) && fifo_in_ready && !fifo_in_valid &&
                        ((state == ST_FWD) || (state == ST_DROP));
  assign tmo_hit      = starved && (tmo_cnt == TMO_ONE);
  assign fwd_load     = (state == ST_FWD) && in_fire;
  assign pad_load     = (state == ST_PAD) && out_loadable;
  assign reject       = ((state == ST_IDLE) && in_fire && !hdr_ok) || tmo_hit;

  // Input ready depends only on state and the output register occupancy.
  always_comb begin
    fifo_in_ready = 1'b1;
    case (state)
      ST_FWD:  fifo_in_ready = out_loadable;
      ST_PAD:  fifo_in_ready = 1'b0;
      default: fifo_in_ready = 1'b1;
    endcase
  end

  // Packet parser: header decode, payload/discard counting and timeout.
  // A zero-length header is rejected without leaving IDLE, so the next word
  // is parsed as a header with no payload consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      tmo_cnt   <= '0;
      cur_type  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            cur_type  <= fifo_in_data[15:12];
            remaining <= hdr_len;
            tmo_cnt   <= TMO_LOAD;
            if (hdr_ok)
              state <= ST_FWD;
            else if (hdr_len != 12'd0)
              state <= ST_DROP;
          end
        end
        ST_FWD, ST_DROP: begin
          if (in_fire) begin
            remaining <= remaining - 12'd1;
            tmo_cnt   <= TMO_LOAD;
            if (remaining == 12'd1)
              state <= ST_IDLE;
          end else if (tmo_hit) begin
            state <= (state == ST_FWD) ? ST_PAD : ST_IDLE;
          end else if (starved) begin
            tmo_cnt <= tmo_cnt - TMO_ONE;
          end
        end
        default: begin
          if (out_loadable)
            state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: loaded with payload or abort filler, cleared on consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      pkt_type  <= '0;
      pkt_last  <= 1'b0;
      pkt_err   <= 1'b0;
    end else if (fwd_load) begin
      pkt_valid <= 1'b1;
      pkt_data  <= fifo_in_data;
      pkt_type  <= cur_type;
      pkt_last  <= (remaining == 12'd1);
      pkt_err   <= 1'b0;
    end else if (pad_load) begin
      pkt_valid <= 1'b1;
      pkt_data  <= '0;
      pkt_type  <= cur_type;
      pkt_last  <= 1'b1;
      pkt_err   <= 1'b1;
    end else if (pkt_ready) begin
      pkt_valid <= 1'b0;
    end
  end

  // Drop pulse and saturating error counter, one increment per reject event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop      <= 1'b0;
      err_count <= '0;
    end else begin
      drop <= reject;
      if (reject && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_glip_packet_depacketizer.sv
// Testbench for glip_packet_depacketizer: directed scenarios plus randomized
// traffic checked against a packet-level reference model (expected word queue).
module tb_glip_packet_depacketizer;

  localparam int MAX_LEN = 4;
  localparam int TIMEOUT = 8;

  localparam int PH_HDR  = 0;
  localparam int PH_PAY  = 1;
  localparam int PH_SKIP = 2;
  localparam int PH_PAD  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_in_valid = 1'b0;
  logic [15:0] fifo_in_data = '0;
  logic        fifo_in_ready;
  logic        pkt_valid;
  logic [15:0] pkt_data;
  logic [3:0]  pkt_type;
  logic        pkt_last;
  logic        pkt_err;
  logic        pkt_ready = 1'b0;
  logic        drop;
  logic [7:0]  err_count;

  glip_packet_depacketizer #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .fifo_in_valid(fifo_in_valid), .fifo_in_data(fifo_in_data), .fifo_in_ready(fifo_in_ready),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_type(pkt_type), .pkt_last(pkt_last),
    .pkt_err(pkt_err), .pkt_ready(pkt_ready), .drop(drop), .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  // pkt_ready source: 0 = driven by main sequence, 1 = random, 2 = pattern 1,0,0
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 1) pkt_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 2) pkt_ready = ((cyc % 3) == 0);
  end

  // ---------------- reference model ----------------
  logic [21:0] exp_q[$];
  int          ph = PH_HDR;
  int          m_rem = 0;
  int          m_starve = 0;
  int          m_len = 0;
  logic [3:0]  m_type = '0;
  logic [7:0]  m_err = '0;
  logic        m_drop = 1'b0;
  logic        m_rdy, m_load_ok, m_fire;
  logic        prev_hold = 1'b0;
  logic [21:0] prev_word = '0;
  logic [21:0] cur, m_got;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      ph = PH_HDR; m_err = '0; m_drop = 1'b0; m_starve = 0; m_rem = 0; prev_hold = 1'b0;
    end else begin
      check("drop", 32'(drop), 32'(m_drop));
      check("err_count", 32'(err_count), 32'(m_err));
      m_drop = 1'b0;
      cur = {pkt_err, pkt_last, pkt_type, pkt_data};
      if (prev_hold) check("hold", 32'({pkt_valid, cur}), 32'({1'b1, prev_word}));
      prev_hold = pkt_valid && !pkt_ready;
      prev_word = cur;
      m_load_ok = !pkt_valid || pkt_ready;
      case (ph)
        PH_PAY:  m_rdy = m_load_ok;
        PH_PAD:  m_rdy = 1'b0;
        default: m_rdy = 1'b1;
      endcase
      check("in_ready", 32'(fifo_in_ready), 32'(m_rdy));
      if (pkt_valid && pkt_ready) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          m_got = exp_q.pop_front();
          check("out_word", 32'(cur), 32'(m_got));
        end
      end
      m_fire = fifo_in_valid && m_rdy;
      case (ph)
        PH_HDR: if (m_fire) begin
          m_len = int'(fifo_in_data[11:0]);
          m_type = fifo_in_data[15:12];
          m_rem = m_len; m_starve = 0;
          if (m_len >= 1 && m_len <= MAX_LEN) ph = PH_PAY;
          else begin
            m_drop = 1'b1;
            if (m_err != 8'hFF) m_err++;
            if (m_len != 0) ph = PH_SKIP;
          end
        end
        PH_PAY, PH_SKIP: begin
          if (m_fire) begin
            if (ph == PH_PAY) exp_q.push_back({1'b0, (m_rem == 1), m_type, fifo_in_data});
            m_rem--; m_starve = 0;
            if (m_rem == 0) ph = PH_HDR;
          end else if (m_rdy) begin
            m_starve++;
            if (TIMEOUT != 0 && m_starve == TIMEOUT) begin
              m_drop = 1'b1;
              if (m_err != 8'hFF) m_err++;
              ph = (ph == PH_PAY) ? PH_PAD : PH_HDR;
            end
          end
        end
        default: if (m_load_ok) begin
          exp_q.push_back({2'b11, m_type, 16'h0000});
          ph = PH_HDR;
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [15:0] d);
    int unsigned w;
    w = 0;
    fifo_in_valid = 1'b1; fifo_in_data = d;
    @(negedge clk);
    while (!fifo_in_ready && w < 200) begin @(negedge clk); w++; end
    if (!fifo_in_ready) check("push_wait", 32'(fifo_in_ready), 32'd1);
    @(posedge clk); #1;
    fifo_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    fifo_in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int unsigned t0;
  int          len;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(pkt_valid), 32'd0);
    check("rst_data", 32'(pkt_data), 32'd0);
    check("rst_type", 32'(pkt_type), 32'd0);
    check("rst_last", 32'(pkt_last), 32'd0);
    check("rst_err", 32'(pkt_err), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    rst = 1'b0;
    idle(1);
    check("rdy_after_rst", 32'(fifo_in_ready), 32'd1);

    // basic 3-word packet, latency
    pkt_ready = 1'b1;
    push(16'h3003);
    check("lat_n1_valid", 32'(pkt_valid), 32'd0);
    push(16'hA001);
    check("lat_n2_valid", 32'(pkt_valid), 32'd1);
    check("lat_n2_data", 32'(pkt_data), 32'hA001);
    check("lat_n2_type", 32'(pkt_type), 32'd3);
    check("lat_n2_last", 32'(pkt_last), 32'd0);
    push(16'hB002);
    push(16'hC003);
    check("c_last", 32'(pkt_last), 32'd1);
    idle(3);

    // same packet under 1,0,0 backpressure
    rdy_mode = 2;
    push(16'h3003); push(16'hA001); push(16'hB002); push(16'hC003);
    idle(10);
    rdy_mode = 0; pkt_ready = 1'b1;
    idle(2);

    // oversize packet swallowed, legal max-size forwarded, zero length
    push(16'h1005);
    for (int i = 0; i < 5; i++) push(16'hD000 + 16'(i));
    check("oversize_err", 32'(err_count), 32'd1);
    push(16'h2004);
    for (int i = 0; i < 4; i++) push(16'hE000 + 16'(i));
    idle(4);
    push(16'h5000);
    check("len0_drop", 32'(drop), 32'd1);
    check("len0_err", 32'(err_count), 32'd2);
    push(16'h9001);
    push(16'h1234);
    idle(3);

    // timeout abort with pkt_ready high
    push(16'h7004); push(16'h0101); push(16'h0202);
    idle(7);
    check("tmo_early_drop", 32'(drop), 32'd0);
    idle(1);
    check("tmo_drop", 32'(drop), 32'd1);
    check("tmo_err", 32'(err_count), 32'd3);
    check("tmo_in_rdy", 32'(fifo_in_ready), 32'd0);
    idle(1);
    check("fill_valid", 32'(pkt_valid), 32'd1);
    check("fill_word", 32'({pkt_err, pkt_last, pkt_data}), 32'h30000);
    check("fill_type", 32'(pkt_type), 32'd7);
    idle(3);

    // backpressure during the gap never times out
    push(16'h7004); push(16'h0101); push(16'h0202);
    pkt_ready = 1'b0;
    idle(20);
    check("bp_no_abort", 32'(err_count), 32'd3);
    pkt_ready = 1'b1;
    push(16'h0303); push(16'h0404);
    idle(3);

    // back-to-back packets, no bubbles
    t0 = cyc;
    push(16'h2002); push(16'h1111); push(16'h2222); push(16'h5001); push(16'h3333);
    check("b2b_cycles", 32'(cyc - t0), 32'd5);
    idle(3);

    // error counter saturation
    for (int i = 0; i < 300; i++) push({4'(i), 12'h000});
    idle(2);
    check("sat_err", 32'(err_count), 32'hFF);

    // reset mid-packet
    push(16'h4003); push(16'h4444);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(pkt_valid), 32'd0);
    check("mid_rst_last", 32'(pkt_last), 32'd0);
    check("mid_rst_data", 32'(pkt_data), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_rdy", 32'(fifo_in_ready), 32'd1);
    push(16'h6001); push(16'h6666);
    idle(1);
    check("post_rst_type", 32'(pkt_type), 32'd6);
    idle(2);

    // randomized traffic against the model
    rdy_mode = 1;
    for (int p = 0; p < 150; p++) begin
      len = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      push({4'($urandom_range(0, 15)), 12'(len)});
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        push(16'($urandom));
      end
    end
    rdy_mode = 0; pkt_ready = 1'b1;
    idle(20);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
